adc_sample_bank: RTL and testbench
==================================

# adc_sample_bank

Parametrised multi-channel sample capture for the SPI ADC path: decodes the channel address in each returned ADC word, routes the conversion result to a per-channel register, and optionally averages 2^AVG_LOG2 conversions per channel before publishing. It sits between spi_master/adc_cntrl and the control loop. It supplies the ADC configuration words on tx_data and presents per-channel samples with one-cycle valid strobes.

## Interface
- NUM_CH, 4: number of channels captured, 1..8.
- DATA_W, 13: result width taken from rx_data[DATA_W-1:0], 8..13.
- AVG_LOG2, 2: log2 of samples averaged per channel, 0..4.
- CTRL_WORD, 16'h8038: ADC control register word.
- RANGE_WORD, 16'hAAA0: ADC range register word.

- clk  in  1  system clock, 10 MHz.
- rst  in  1  asynchronous, active-high reset.
- sel_tx  in  2  tx word select, driven by adc_cntrl.
- tx_data  out  16  word to spi_master.
- load_data  in  1  one-cycle strobe: rx_data holds a complete ADC word.
- rx_data  in  16  ADC word: [15:13] channel address, [DATA_W-1:0] result.
- avg_en  in  1  1 = average 2^AVG_LOG2 samples; 0 = bypass.
- clear  in  1  synchronous clear of accumulators, counters and err_flag.
- samples  out  NUM_CH*DATA_W  channel k at [k*DATA_W +: DATA_W].
- sample_valid  out  NUM_CH  bit k pulses one cycle when samples slice k updates.
- ch_err  out  1  one-cycle pulse when a word addresses a channel >= NUM_CH.
- err_flag  out  1  sticky copy of ch_err; cleared by clear or rst.

## Operation
- tx_data is combinational and fully specified:
  - sel_tx 0 gives 16'h0000.
  - sel_tx 1 gives CTRL_WORD.
  - sel_tx 2 gives RANGE_WORD.
  - sel_tx 3 gives 16'h0000.
  - No latch is inferred.
- Channel decode: ch = rx_data[15:13], result d = rx_data[DATA_W-1:0]. Any bits between DATA_W and 12 are ignored.
- Out-of-range channel (ch >= NUM_CH) with load_data:
  - The word is dropped.
  - ch_err pulses and err_flag sets.
  - No channel state changes.
- Per-channel state:
  - Accumulator acc[k], width DATA_W+AVG_LOG2, unsigned.
  - Counter cnt[k], width max(AVG_LOG2,1).
  - Output register samples slice k.
- Averaging (avg_en=1, AVG_LOG2>0), on load_data for a valid ch:
  - If cnt[ch] < 2^AVG_LOG2-1: acc[ch] += d and cnt[ch]++.
  - Otherwise: samples[ch] <= (acc[ch]+d) >> AVG_LOG2 (truncating), acc[ch] <= 0, cnt[ch] <= 0, and sample_valid[ch] pulses.
- Bypass (avg_en=0 or AVG_LOG2=0):
  - Every valid load does samples[ch] <= d and pulses sample_valid[ch].
  - While avg_en=0, all acc and cnt are held at 0, so re-enabling starts a fresh window.
- clear:
  - Zeroes all acc and cnt, and clears err_flag.
  - Does not alter samples.
  - clear together with load_data: clear wins; the word is dropped with no valid and no ch_err.
- Channels are independent. A window in progress on one channel is unaffected by loads to other channels.

## Timing
- Reset (async assert, applied immediately):
  - samples, acc and cnt are all 0.
  - sample_valid = 0, ch_err = 0, err_flag = 0.
  - tx_data still follows sel_tx.
- Reset mid-window discards partial accumulations. The first window after reset needs the full 2^AVG_LOG2 samples.
- Latency: a load_data at edge n updates samples at edge n. sample_valid and ch_err are high in the cycle following edge n (registered), for exactly one cycle.
- load_data on consecutive cycles is supported at full rate. Back-to-back completions on the same channel give back-to-back valid pulses.
- No overflow is possible: acc holds 2^AVG_LOG2 × (2^DATA_W-1).

## Test plan
- Reset then sel_tx 0,1,2,3 -> tx_data 0000, 8038, AAA0, 0000; all outputs 0; assert rst mid-window -> outputs 0 asynchronously.
- avg_en=1, AVG_LOG2=2, four loads to ch1 with d = 100, 101, 102, 104 -> after the 4th, samples[1]=101 (407>>2) and sample_valid=4'b0010 for one cycle; no pulse after loads 1–3.
- avg_en=1, interleaved loads ch0 = 8191 ×4 and ch2 = 0 ×4 -> samples[0]=8191 and samples[2]=0, each channel's valid pulsing once at its 4th sample.
- avg_en=0, loads ch3 = 0x0ABC, then ch0 = 0x1FFF on the next cycle -> samples[3]=0x0ABC and samples[0]=0x1FFF, with valid pulses on consecutive cycles.
- NUM_CH=4, load with rx_data[15:13]=5 -> ch_err pulses once, err_flag=1, samples unchanged; then clear -> err_flag=0.
- Two loads to ch0, then clear asserted on the same cycle as a 3rd load, then 4 more loads of 40 -> no valid until the 4th post-clear load, which gives samples[0]=40.

Source files
------------

// File: rtl/adc_sample_bank_if.sv
// Bus between adc_cntrl/spi_master/control loop and the sample bank.
// Carries the tx word select, returned ADC words and published samples.
interface adc_sample_bank_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 13
);
    logic [1:0]               sel_tx;
    logic [15:0]              tx_data;
    logic                     load_data;
    logic [15:0]              rx_data;
    logic                     avg_en;
    logic                     clear;
    logic [NUM_CH*DATA_W-1:0] samples;
    logic [NUM_CH-1:0]        sample_valid;
    logic                     ch_err;
    logic                     err_flag;

    modport master (
        output sel_tx, load_data, rx_data, avg_en, clear,
        input  tx_data, samples, sample_valid, ch_err, err_flag
    );
    modport slave (
        input  sel_tx, load_data, rx_data, avg_en, clear,
        output tx_data, samples, sample_valid, ch_err, err_flag
    );
endinterface

// File: rtl/adc_sample_bank.sv
// Multi-channel ADC sample capture: decodes channel address, routes results
// to per-channel lanes that optionally average 2^AVG_LOG2 conversions.

module adc_sample_lane #(
    parameter int DATA_W   = 13,
    parameter int AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic [DATA_W-1:0] d,
    input  logic              avg_en,
    input  logic              clear,
    output logic [DATA_W-1:0] sample,
    output logic              valid
);
    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam bit AVG_OK = (AVG_LOG2 > 0);

    logic [ACC_W-1:0] acc, sum;
    logic [CNT_W-1:0] cnt;
    logic             avg_on;

    assign avg_on = avg_en && AVG_OK;
    assign sum    = acc + ACC_W'(d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            cnt    <= '0;
            sample <= '0;
            valid  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (clear) begin
                acc <= '0;
                cnt <= '0;
            end else if (!avg_on) begin
                // bypass keeps the window empty so re-enabling starts fresh
                acc <= '0;
                cnt <= '0;
                if (ld) begin
                    sample <= d;
                    valid  <= 1'b1;
                end
            end else if (ld) begin
                if (cnt != LAST) begin
                    acc <= sum;
                    cnt <= cnt + 1'b1;
                end else begin
                    sample <= sum[AVG_LOG2 +: DATA_W];
                    acc    <= '0;
                    cnt    <= '0;
                    valid  <= 1'b1;
                end
            end
        end
    end
endmodule

module adc_sample_bank #(
    parameter int          NUM_CH     = 4,
    parameter int          DATA_W     = 13,
    parameter int          AVG_LOG2   = 2,
    parameter logic [15:0] CTRL_WORD  = 16'h8038,
    parameter logic [15:0] RANGE_WORD = 16'hAAA0
) (
    input logic              clk,
    input logic              rst,
    adc_sample_bank_if.slave bus
);
    logic [2:0]                   ch;
    logic [DATA_W-1:0]            d;
    logic                         ch_ok;
    logic                         take;
    logic [NUM_CH-1:0][DATA_W-1:0] samp;
    logic [NUM_CH-1:0]            vld;
    logic                         ch_err_q, err_flag_q;

    assign ch    = bus.rx_data[15:13];
    assign d     = bus.rx_data[DATA_W-1:0];
    assign ch_ok = ({1'b0, ch} < 4'(NUM_CH));
    // clear wins over a coincident load: the word is silently dropped
    assign take  = bus.load_data && !bus.clear;

    always_comb begin
        bus.tx_data = 16'h0000;
        case (bus.sel_tx)
            2'd1:    bus.tx_data = CTRL_WORD;
            2'd2:    bus.tx_data = RANGE_WORD;
            default: bus.tx_data = 16'h0000;
        endcase
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        adc_sample_lane #(
            .DATA_W   (DATA_W),
            .AVG_LOG2 (AVG_LOG2)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .ld     (take && (ch == 3'(k))),
            .d      (d),
            .avg_en (bus.avg_en),
            .clear  (bus.clear),
            .sample (samp[k]),
            .valid  (vld[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_err_q   <= 1'b0;
            err_flag_q <= 1'b0;
        end else begin
            ch_err_q <= take && !ch_ok;
            if (bus.clear)
                err_flag_q <= 1'b0;
            else if (take && !ch_ok)
                err_flag_q <= 1'b1;
        end
    end

    assign bus.samples      = samp;
    assign bus.sample_valid = vld;
    assign bus.ch_err       = ch_err_q;
    assign bus.err_flag     = err_flag_q;
endmodule

// File: tb/tb_adc_sample_bank.sv
// Self-checking bench for adc_sample_bank: directed scenarios with literal
// expectations plus randomized traffic against a window-averaging model.
module tb_adc_sample_bank;
    localparam int NUM_CH   = 4;
    localparam int DATA_W   = 13;
    localparam int AVG_LOG2 = 2;
    localparam int N        = 1 << AVG_LOG2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #50 clk = ~clk;

    adc_sample_bank_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    adc_sample_bank #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2),
        .CTRL_WORD(16'h8038), .RANGE_WORD(16'hAAA0)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [DATA_W-1:0] slice(input int k);
        return bus.samples[k*DATA_W +: DATA_W];
    endfunction

    // Behavioural model: each channel collects a window of N results and
    // publishes floor(sum/N) when the window is full; bypass publishes raw.
    int m_sum [NUM_CH];
    int m_n   [NUM_CH];
    int m_samp[NUM_CH];
    bit [NUM_CH-1:0] m_valid;
    bit m_err, m_flag;
    int mc, md;
    logic [15:0] tx_tab [4];

    initial begin
        tx_tab[0] = 16'h0000; tx_tab[1] = 16'h8038;
        tx_tab[2] = 16'hAAA0; tx_tab[3] = 16'h0000;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                m_sum[k] = 0; m_n[k] = 0; m_samp[k] = 0;
            end
            m_valid = '0; m_err = 0; m_flag = 0;
        end else begin
            m_valid = '0;
            m_err   = 0;
            mc = int'(bus.rx_data[15:13]);
            md = int'(bus.rx_data[DATA_W-1:0]);
            if (bus.clear) begin
                for (int k = 0; k < NUM_CH; k++) begin m_sum[k] = 0; m_n[k] = 0; end
                m_flag = 0;
            end else begin
                if (!bus.avg_en)
                    for (int k = 0; k < NUM_CH; k++) begin m_sum[k] = 0; m_n[k] = 0; end
                if (bus.load_data) begin
                    if (mc >= NUM_CH) begin
                        m_err = 1; m_flag = 1;
                    end else if (!bus.avg_en || AVG_LOG2 == 0) begin
                        m_samp[mc] = md; m_valid[mc] = 1'b1;
                    end else begin
                        m_sum[mc] += md;
                        m_n[mc]++;
                        if (m_n[mc] == N) begin
                            m_samp[mc] = m_sum[mc] / N;
                            m_sum[mc] = 0; m_n[mc] = 0;
                            m_valid[mc] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < NUM_CH; k++)
            chk($sformatf("model_samples[%0d]", k), 64'(slice(k)), 64'(m_samp[k]));
        chk("model_sample_valid", 64'(bus.sample_valid), 64'(m_valid));
        chk("model_ch_err", 64'(bus.ch_err), 64'(m_err));
        chk("model_err_flag", 64'(bus.err_flag), 64'(m_flag));
        chk("model_tx_data", 64'(bus.tx_data), 64'(tx_tab[bus.sel_tx]));
    end

    task automatic step(input bit ld, input int ch, input int d, input bit clr = 1'b0);
        bus.load_data = ld;
        bus.rx_data   = {3'(ch), 13'(d)};
        bus.clear     = clr;
        @(posedge clk);
        #1;
        bus.load_data = 1'b0;
        bus.clear     = 1'b0;
    endtask

    initial begin
        bus.sel_tx = 2'd0; bus.load_data = 1'b0; bus.rx_data = '0;
        bus.avg_en = 1'b1; bus.clear = 1'b0;
        #1 rst = 1'b1;
        #20;
        chk("rst_samples", 64'(bus.samples), 64'd0);
        chk("rst_valid", 64'(bus.sample_valid), 64'd0);
        chk("rst_ch_err", 64'(bus.ch_err), 64'd0);
        chk("rst_err_flag", 64'(bus.err_flag), 64'd0);
        bus.sel_tx = 2'd0; #1 chk("tx_sel0", 64'(bus.tx_data), 64'h0000);
        bus.sel_tx = 2'd1; #1 chk("tx_sel1", 64'(bus.tx_data), 64'h8038);
        bus.sel_tx = 2'd2; #1 chk("tx_sel2", 64'(bus.tx_data), 64'hAAA0);
        bus.sel_tx = 2'd3; #1 chk("tx_sel3", 64'(bus.tx_data), 64'h0000);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // averaging window on ch1
        step(1, 1, 100); step(1, 1, 101); step(1, 1, 102);
        chk("avg_no_early_valid", 64'(bus.sample_valid), 64'd0);
        step(1, 1, 104);
        chk("avg_ch1_value", 64'(slice(1)), 64'd101);
        chk("avg_ch1_valid", 64'(bus.sample_valid), 64'b0010);
        step(0, 0, 0);
        chk("avg_valid_one_cycle", 64'(bus.sample_valid), 64'd0);

        // interleaved extremes
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 8191);
            step(1, 2, 0);
        end
        step(0, 0, 0);
        chk("intl_ch0_max", 64'(slice(0)), 64'd8191);
        chk("intl_ch2_zero", 64'(slice(2)), 64'd0);

        // bypass, back-to-back
        bus.avg_en = 1'b0;
        step(1, 3, 'h0ABC);
        chk("byp_ch3_value", 64'(slice(3)), 64'h0ABC);
        chk("byp_ch3_valid", 64'(bus.sample_valid), 64'b1000);
        step(1, 0, 'h1FFF);
        chk("byp_ch0_value", 64'(slice(0)), 64'h1FFF);
        chk("byp_ch0_valid", 64'(bus.sample_valid), 64'b0001);
        step(0, 0, 0);

        // out-of-range channel
        step(1, 5, 'h123);
        chk("err_pulse", 64'(bus.ch_err), 64'd1);
        chk("err_flag_set", 64'(bus.err_flag), 64'd1);
        chk("err_samples_kept", 64'(bus.samples),
            64'({13'h0ABC, 13'h0000, 13'd101, 13'h1FFF}));
        chk("err_no_valid", 64'(bus.sample_valid), 64'd0);
        step(0, 0, 0);
        chk("err_pulse_one_cycle", 64'(bus.ch_err), 64'd0);
        chk("err_flag_sticky", 64'(bus.err_flag), 64'd1);
        step(0, 0, 0, 1'b1);
        chk("err_flag_cleared", 64'(bus.err_flag), 64'd0);

        // clear drops a partial window and a coincident load
        bus.avg_en = 1'b1;
        step(1, 0, 7); step(1, 0, 9);
        step(1, 0, 99, 1'b1);
        chk("clr_load_no_valid", 64'(bus.sample_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 40);
            chk("clr_no_valid_pre4", 64'(bus.sample_valid), 64'd0);
        end
        step(1, 0, 40);
        chk("clr_post4_valid", 64'(bus.sample_valid), 64'b0001);
        chk("clr_post4_value", 64'(slice(0)), 64'd40);

        // asynchronous reset mid-window
        step(1, 1, 500); step(1, 1, 600);
        #20 rst = 1'b1;
        #1;
        chk("async_rst_samples", 64'(bus.samples), 64'd0);
        chk("async_rst_valid", 64'(bus.sample_valid), 64'd0);
        chk("async_rst_flag", 64'(bus.err_flag), 64'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) step(1, 1, 40);
        chk("rst_window_no_valid", 64'(bus.sample_valid), 64'd0);
        step(1, 1, 40);
        chk("rst_window_value", 64'(slice(1)), 64'd40);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 29) == 0) bus.avg_en = ~bus.avg_en;
            bus.sel_tx = 2'($urandom_range(0, 3));
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 5)),
                 int'($urandom_range(0, 8191)), 1'($urandom_range(0, 24) == 0));
        end
        step(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
